prot_exception_check: RTL and testbench

Protection-limit checker on the consumer side of the RrAg end-address adder. Takes the ending byte address of a memory access (displacement + register sum + access size, plus adder carry-out) with its segment, compares it against per-segment limit registers, and flags a protection exception. Two-stage valid/ready pipeline between RrAg and the memory-access stage. Keeps a sticky record of the first fault for the exception handler.

---
 rtl/prot_exception_check_pkg.sv | 29 ++
 rtl/prot_exception_check_if.sv | 48 ++++
 rtl/prot_limit_regfile.sv | 73 +++++++
 rtl/prot_exception_check.sv | 152 +++++++++++++++
 tb/tb_prot_exception_check.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prot_exception_check_pkg.sv
// Shared types and constants for the protection-limit checker.
// Optional feature macro: PROT_WRITE_CHECK_EN (per-segment writable bits).
package prot_exception_check_pkg;

   localparam int NSEG = 6;
   localparam int AW   = 32;

   localparam logic [2:0] SEG_ES = 3'd0;
   localparam logic [2:0] SEG_CS = 3'd1;
   localparam logic [2:0] SEG_SS = 3'd2;
   localparam logic [2:0] SEG_DS = 3'd3;
   localparam logic [2:0] SEG_FS = 3'd4;
   localparam logic [2:0] SEG_GS = 3'd5;

   localparam logic [AW-1:0] LIM_RST = '1;

   typedef struct packed {
      logic [AW-1:0] end_addr;
      logic          carry;
      logic [2:0]    seg;
      logic          is_write;
      logic [7:0]    tag;
   } req_t;

   function automatic logic seg_in_range(logic [2:0] seg, int nseg);
      return int'(seg) < nseg;
   endfunction

endpackage

// File: rtl/prot_exception_check_if.sv
// Request/result handshake bundle between RrAg, the checker and
// the memory-access stage.
interface prot_exception_check_if #(
   parameter int AW = 32
) ();

   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_end_addr;
   logic          in_carry;
   logic [2:0]    in_seg;
   logic          in_is_write;
   logic [7:0]    in_tag;

   logic          out_valid;
   logic          out_ready;
   logic          out_fault;
   logic [7:0]    out_tag;

   modport master (
      output in_valid,
      output in_end_addr,
      output in_carry,
      output in_seg,
      output in_is_write,
      output in_tag,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_fault,
      input  out_tag
   );

   modport slave (
      input  in_valid,
      input  in_end_addr,
      input  in_carry,
      input  in_seg,
      input  in_is_write,
      input  in_tag,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_fault,
      output out_tag
   );

endinterface

// File: rtl/prot_limit_regfile.sv
// Per-segment limit storage with a write-first read port.
// Writable bits exist only when PROT_WRITE_CHECK_EN is defined.
module prot_limit_regfile #(
   parameter int NSEG = 6,
   parameter int AW   = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [2:0]    sel,
   input  logic [AW-1:0] wdata,
   input  logic          wr_ok,
   input  logic [2:0]    rd_sel,
   output logic [AW-1:0] rd_lim,
   output logic          rd_wr_ok
);

   import prot_exception_check_pkg::*;

   logic [AW-1:0] lim_q [NSEG];
   logic          wr_hit;

   assign wr_hit = we && seg_in_range(sel, NSEG);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NSEG; i++) begin
            lim_q[i] <= '1;
         end
      end else if (wr_hit) begin
         for (int i = 0; i < NSEG; i++) begin
            if (sel == 3'(i)) lim_q[i] <= wdata;
         end
      end
   end

   // Same-cycle write to the read index wins over the stored value.
   always_comb begin
      rd_lim = '1;
      for (int i = 0; i < NSEG; i++) begin
         if (rd_sel == 3'(i)) rd_lim = lim_q[i];
      end
      if (wr_hit && (sel == rd_sel)) rd_lim = wdata;
   end

`ifdef PROT_WRITE_CHECK_EN
   logic [NSEG-1:0] wr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q <= '1;
      end else if (wr_hit) begin
         for (int i = 0; i < NSEG; i++) begin
            if (sel == 3'(i)) wr_q[i] <= wr_ok;
         end
      end
   end

   always_comb begin
      rd_wr_ok = 1'b1;
      for (int i = 0; i < NSEG; i++) begin
         if (rd_sel == 3'(i)) rd_wr_ok = wr_q[i];
      end
      if (wr_hit && (sel == rd_sel)) rd_wr_ok = wr_ok;
   end
`else
   logic unused_wr_ok;

   assign unused_wr_ok = wr_ok;
   assign rd_wr_ok     = 1'b1;
`endif

endmodule

// File: rtl/prot_exception_check.sv
// Two-stage protection-limit checker with sticky first-fault record.
// Optional macro PROT_WRITE_CHECK_EN adds store-to-readonly faults.
module prot_exception_check #(
   parameter int NSEG = 6,
   parameter int AW   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prot_exception_check_if.slave bus,
   input  logic                  lim_we,
   input  logic [2:0]            lim_sel,
   input  logic [AW-1:0]         lim_wdata,
   input  logic                  lim_wr_ok,
   input  logic                  flush,
   output logic                  exc_valid,
   output logic [2:0]            exc_seg,
   output logic [AW-1:0]         exc_addr,
   input  logic                  exc_clear
);

   import prot_exception_check_pkg::*;

   req_t          in_req;
   logic [AW-1:0] rd_lim;
   logic          rd_wr_ok;

   logic          s1_valid;
   req_t          s1_req;
   logic [AW-1:0] s1_lim;
   logic          s1_wr_ok;
   logic          s1_fault;

   logic          s2_valid;
   logic          s2_fault;
   logic [7:0]    s2_tag;
   logic [2:0]    s2_seg;
   logic [AW-1:0] s2_addr;

   logic          s1_load;
   logic          s2_load;
   logic          accept;
   logic          xfer_fault;

   assign in_req = '{
      end_addr: bus.in_end_addr,
      carry:    bus.in_carry,
      seg:      bus.in_seg,
      is_write: bus.in_is_write,
      tag:      bus.in_tag
   };

   prot_limit_regfile #(
      .NSEG (NSEG),
      .AW   (AW)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (lim_we),
      .sel      (lim_sel),
      .wdata    (lim_wdata),
      .wr_ok    (lim_wr_ok),
      .rd_sel   (bus.in_seg),
      .rd_lim   (rd_lim),
      .rd_wr_ok (rd_wr_ok)
   );

   assign s2_load     = !s2_valid || bus.out_ready;
   assign s1_load     = !s1_valid || s2_load;
   assign accept      = bus.in_valid && s1_load;
   assign bus.in_ready = s1_load;

   always_comb begin
      s1_fault = s1_req.carry
              || (s1_req.end_addr > s1_lim)
              || !seg_in_range(s1_req.seg, NSEG);
`ifdef PROT_WRITE_CHECK_EN
      if (s1_req.is_write && !s1_wr_ok) s1_fault = 1'b1;
`endif
   end

`ifndef PROT_WRITE_CHECK_EN
   logic unused_wr;

   assign unused_wr = ^{s1_req.is_write, s1_wr_ok};
`endif

   // Limit is captured at acceptance so later writes cannot
   // retroactively change the verdict of an in-flight request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_req   <= '0;
         s1_lim   <= '1;
         s1_wr_ok <= 1'b1;
      end else begin
         if (flush) begin
            s1_valid <= 1'b0;
         end else if (s1_load) begin
            s1_valid <= bus.in_valid;
         end
         if (accept) begin
            s1_req   <= in_req;
            s1_lim   <= rd_lim;
            s1_wr_ok <= rd_wr_ok;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_fault <= 1'b0;
         s2_tag   <= '0;
         s2_seg   <= '0;
         s2_addr  <= '0;
      end else begin
         if (flush) begin
            s2_valid <= 1'b0;
         end else if (s2_load) begin
            s2_valid <= s1_valid;
         end
         if (s2_load && s1_valid) begin
            s2_fault <= s1_fault;
            s2_tag   <= s1_req.tag;
            s2_seg   <= s1_req.seg;
            s2_addr  <= s1_req.end_addr;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_fault = s2_fault;
   assign bus.out_tag   = s2_tag;

   assign xfer_fault = s2_valid && bus.out_ready && s2_fault;

   // A new fault leaving in the clear cycle replaces the old record.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exc_valid <= 1'b0;
         exc_seg   <= '0;
         exc_addr  <= '0;
      end else if (xfer_fault && (!exc_valid || exc_clear)) begin
         exc_valid <= 1'b1;
         exc_seg   <= s2_seg;
         exc_addr  <= s2_addr;
      end else if (exc_clear) begin
         exc_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prot_exception_check.sv
// Scoreboard bench for prot_exception_check: directed vectors,
// expected results queued at issue and popped by an output monitor.
module tb_prot_exception_check;

   import prot_exception_check_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        lim_we;
   logic [2:0]  lim_sel;
   logic [31:0] lim_wdata;
   logic        lim_wr_ok;
   logic        flush;
   logic        exc_valid;
   logic [2:0]  exc_seg;
   logic [31:0] exc_addr;
   logic        exc_clear;

   int n_checks;
   int n_fail;

   logic [8:0] sb_q[$];

   prot_exception_check_if #(.AW(32)) bus ();

   prot_exception_check #(
      .NSEG (6),
      .AW   (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .lim_we    (lim_we),
      .lim_sel   (lim_sel),
      .lim_wdata (lim_wdata),
      .lim_wr_ok (lim_wr_ok),
      .flush     (flush),
      .exc_valid (exc_valid),
      .exc_seg   (exc_seg),
      .exc_addr  (exc_addr),
      .exc_clear (exc_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got tag 0x%0h expected none",
                     bus.out_tag);
         end else begin
            logic [8:0] e;
            e = sb_q.pop_front();
            chk("out_tag", 64'(bus.out_tag), 64'(e[7:0]));
            chk("out_fault", 64'(bus.out_fault), 64'(e[8]));
         end
      end
   end

   task automatic drive(input logic [7:0] tag, input logic [2:0] seg,
                        input logic [31:0] addr, input logic carry,
                        input logic wr);
      bus.in_valid    = 1'b1;
      bus.in_tag      = tag;
      bus.in_seg      = seg;
      bus.in_end_addr = addr;
      bus.in_carry    = carry;
      bus.in_is_write = wr;
   endtask

   task automatic send(input logic [7:0] tag, input logic [2:0] seg,
                       input logic [31:0] addr, input logic carry,
                       input logic wr, input logic expf);
      logic rdy;
      int   n;
      drive(tag, seg, addr, carry, wr);
      sb_q.push_back({expf, tag});
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 50) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         n++;
      end
      #1;
      bus.in_valid = 1'b0;
      if (!rdy) chk("accept_timeout", 64'(rdy), 64'd1);
   endtask

   task automatic wr_lim(input logic [2:0] sel, input logic [31:0] d,
                         input logic ok);
      lim_we    = 1'b1;
      lim_sel   = sel;
      lim_wdata = d;
      lim_wr_ok = ok;
      @(posedge clk);
      #1;
      lim_we = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n           = 1'b0;
      lim_we          = 1'b0;
      lim_sel         = '0;
      lim_wdata       = '0;
      lim_wr_ok       = 1'b1;
      flush           = 1'b0;
      exc_clear       = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_end_addr = '0;
      bus.in_carry    = 1'b0;
      bus.in_seg      = '0;
      bus.in_is_write = 1'b0;
      bus.in_tag      = '0;
      bus.out_ready   = 1'b1;
      n_checks        = 0;
      n_fail          = 0;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_fault", 64'(bus.out_fault), 64'd0);
      chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_exc_valid", 64'(exc_valid), 64'd0);
      chk("rst_exc_seg", 64'(exc_seg), 64'd0);
      chk("rst_exc_addr", 64'(exc_addr), 64'd0);
      @(posedge clk);
      #1;

      // DS limit boundary
      wr_lim(SEG_DS, 32'h0000_1000, 1'b1);
      send(8'h01, SEG_DS, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
      send(8'h02, SEG_DS, 32'h0000_1001, 1'b0, 1'b0, 1'b1);
      drain();
      chk("exc_valid_first", 64'(exc_valid), 64'd1);
      chk("exc_seg_first", 64'(exc_seg), 64'(SEG_DS));
      chk("exc_addr_first", 64'(exc_addr), 64'h1001);

      // carry-out and out-of-range segment
      send(8'h03, SEG_ES, 32'h0000_0004, 1'b1, 1'b0, 1'b1);
      send(8'h04, 3'd7, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
      send(8'h05, SEG_GS, LIM_RST, 1'b0, 1'b0, 1'b0);
      drain();
      chk("exc_addr_held", 64'(exc_addr), 64'h1001);

      // ignored out-of-range limit write
      wr_lim(3'd6, 32'h0, 1'b1);
      send(8'h06, SEG_GS, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      drain();

      // back-to-back with downstream stall
      bus.out_ready = 1'b0;
      fork
         begin
            send(8'h10, SEG_FS, 32'h10, 1'b0, 1'b0, 1'b0);
            send(8'h11, SEG_FS, 32'h20, 1'b0, 1'b0, 1'b0);
            send(8'h12, SEG_FS, 32'h30, 1'b0, 1'b0, 1'b0);
            send(8'h13, SEG_FS, 32'h40, 1'b0, 1'b0, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_out_tag", 64'(bus.out_tag), 64'h10);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // forwarded limit vs. captured limit
      drive(8'h30, SEG_SS, 32'h20, 1'b0, 1'b0);
      sb_q.push_back({1'b0, 8'h30});
      @(posedge clk);
      #1;
      drive(8'h31, SEG_SS, 32'h20, 1'b0, 1'b0);
      sb_q.push_back({1'b1, 8'h31});
      lim_we    = 1'b1;
      lim_sel   = SEG_SS;
      lim_wdata = 32'h10;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lim_we       = 1'b0;
      send(8'h32, SEG_SS, 32'h10, 1'b0, 1'b0, 1'b0);
      drain();

      // sticky record and coincident clear
      exc_clear = 1'b1;
      @(posedge clk);
      #1;
      exc_clear = 1'b0;
      chk("exc_cleared", 64'(exc_valid), 64'd0);
      send(8'h20, SEG_DS, 32'h2000, 1'b0, 1'b0, 1'b1);
      send(8'h21, SEG_DS, 32'h3000, 1'b0, 1'b0, 1'b1);
      drain();
      chk("exc_addr_hold1", 64'(exc_addr), 64'h2000);
      drive(8'h22, SEG_DS, 32'h4000, 1'b0, 1'b0);
      sb_q.push_back({1'b1, 8'h22});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      exc_clear = 1'b1;
      @(posedge clk);
      #1;
      exc_clear = 1'b0;
      chk("exc_valid_third", 64'(exc_valid), 64'd1);
      chk("exc_addr_third", 64'(exc_addr), 64'h4000);
      drain();

      // write permission
      wr_lim(SEG_CS, 32'h100, 1'b0);
`ifdef PROT_WRITE_CHECK_EN
      send(8'h50, SEG_CS, 32'h8, 1'b0, 1'b1, 1'b1);
`else
      send(8'h50, SEG_CS, 32'h8, 1'b0, 1'b1, 1'b0);
`endif
      send(8'h51, SEG_CS, 32'h8, 1'b0, 1'b0, 1'b0);
      drain();

      // flush kills in-flight request
      drive(8'h40, SEG_GS, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // reset mid-stream
      bus.out_ready = 1'b0;
      drive(8'h60, SEG_ES, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(8'h61, SEG_ES, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("mid_rst_exc_valid", 64'(exc_valid), 64'd0);
      chk("mid_rst_exc_addr", 64'(exc_addr), 64'd0);
      bus.out_ready = 1'b1;
      send(8'h70, SEG_DS, 32'h0000_1001, 1'b0, 1'b0, 1'b0);
      send(8'h71, SEG_SS, LIM_RST, 1'b0, 1'b0, 1'b0);
      send(8'h72, SEG_CS, 32'h8, 1'b0, 1'b1, 1'b0);
      drain();
      chk("end_exc_valid", 64'(exc_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
